// File: rtl/command_control_pkg.sv
// Shared CAPI/AFU types: PSL command/response records and the per-tag bookkeeping line.
package command_control_pkg;

    localparam logic [0:2]  ABT_STRICT        = 3'b000;
    localparam logic [0:15] DEDICATED_CONTEXT = 16'h0000;

    typedef struct packed {
        logic [7:0]  cu_id;
        logic [7:0]  cmd_type;
        logic [15:0] cacheline_id;
    } CommandTagLine;

    typedef struct packed {
        logic        valid;
        logic [0:7]  tag;
        logic        tag_parity;
        logic [0:7]  response;
        logic [0:8]  credits;
    } ResponseInterface;

    typedef struct packed {
        logic          valid;
        logic [0:12]   command;
        logic [0:63]   address;
        logic [0:11]   size;
        CommandTagLine cmd;
    } CommandRequest;

    typedef struct packed {
        logic        valid;
        logic [0:7]  tag;
        logic        tag_parity;
        logic [0:12] command;
        logic        command_parity;
        logic [0:63] address;
        logic        address_parity;
        logic [0:2]  abt;
        logic [0:15] context_handle;
        logic [0:11] size;
    } CommandInterfaceOut;

endpackage

// File: rtl/parity.sv
// Reduction parity over BITS bits; with odd set the result makes the total count of ones odd.
module parity #(
    parameter int unsigned BITS = 8,
    parameter bit          odd  = 1'b1
) (
    input  logic [BITS-1:0] data_i,
    output logic            parity_o
);

    assign parity_o = (^data_i) ^ odd;

endmodule

// File: rtl/command_control.sv
// PSL command issue: tag allocation, credit tracking, odd parity and tag-table response lookup.
// Optional CMD_TAG_CHECK_EN adds sticky error flags and drops responses to non-outstanding tags.
module command_control
    import command_control_pkg::*;
#(
    parameter int unsigned TAG_COUNT    = 32,
    parameter int unsigned CREDIT_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic                    enabled,
    input  logic [CREDIT_WIDTH-1:0] credits_init,
    input  CommandRequest           command_in,
    output logic                    command_ready,
    input  logic                    response_valid,
    input  logic [7:0]              response_tag,
    output CommandInterfaceOut      command_out,
    output CommandTagLine           response_tag_id_out,
    output logic [0:1]              command_error
);

    localparam int unsigned TagW = (TAG_COUNT > 1) ? $clog2(TAG_COUNT) : 1;

    logic [TAG_COUNT-1:0]    free_d, free_q;
    logic [CREDIT_WIDTH-1:0] credits_d, credits_q;
    logic [CREDIT_WIDTH-1:0] credit_max_d, credit_max_q;
    logic                    enabled_q;
    CommandInterfaceOut      cmd_out_d, cmd_out_q;
    CommandTagLine           rsp_line_d, rsp_line_q;
    CommandTagLine           tag_table_q [TAG_COUNT];

    logic [TagW-1:0] alloc_tag;
    logic [7:0]      alloc_tag8;
    logic            accept;
    logic            rsp_in_range;
    logic [TagW-1:0] rsp_idx;
    logic            rsp_free;
    logic            rsp_credit;
    logic            tag_par, cmd_par, addr_par;

    // Lowest-index free tag, taken from the pre-update free map.
    always_comb begin
        alloc_tag = '0;
        for (int i = int'(TAG_COUNT) - 1; i >= 0; i--) begin
            if (free_q[i]) alloc_tag = TagW'(i);
        end
    end

    assign alloc_tag8    = 8'(alloc_tag);
    assign command_ready = enabled && (credits_q != '0) && (free_q != '0);
    assign accept        = command_in.valid && command_ready;
    assign rsp_in_range  = ({24'b0, response_tag} < TAG_COUNT);
    assign rsp_idx       = response_tag[TagW-1:0];

`ifdef CMD_TAG_CHECK_EN
    logic       rsp_busy;
    logic [0:1] err_d, err_q;

    assign rsp_busy   = rsp_in_range && !free_q[rsp_idx];
    assign rsp_free   = response_valid && rsp_busy;
    assign rsp_credit = rsp_free;

    always_comb begin
        err_d = err_q;
        if (response_valid && !rsp_busy) err_d[0] = 1'b1;
        if (rsp_free && (credits_q == credit_max_q)) err_d[1] = 1'b1;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) err_q <= '0;
        else     err_q <= err_d;
    end

    assign command_error = err_q;
`else
    assign rsp_free      = response_valid && rsp_in_range;
    assign rsp_credit    = response_valid;
    assign command_error = '0;
`endif

    parity #(.BITS(8), .odd(1'b1)) u_tag_parity (
        .data_i   (alloc_tag8),
        .parity_o (tag_par)
    );

    parity #(.BITS(13), .odd(1'b1)) u_cmd_parity (
        .data_i   (command_in.command),
        .parity_o (cmd_par)
    );

    parity #(.BITS(64), .odd(1'b1)) u_addr_parity (
        .data_i   (command_in.address),
        .parity_o (addr_par)
    );

    always_comb begin
        // Release first, then allocate, so allocation wins on a same-tag collision.
        free_d = free_q;
        if (rsp_free) free_d[rsp_idx] = 1'b1;
        if (accept)   free_d[alloc_tag] = 1'b0;

        credits_d    = credits_q;
        credit_max_d = credit_max_q;
        if (enabled && !enabled_q) begin
            credits_d    = credits_init;
            credit_max_d = credits_init;
        end else if (accept && !rsp_credit) begin
            credits_d = credits_q - CREDIT_WIDTH'(1);
        end else if (!accept && rsp_credit && (credits_q != credit_max_q)) begin
            credits_d = credits_q + CREDIT_WIDTH'(1);
        end

        cmd_out_d = '0;
        if (accept) begin
            cmd_out_d.valid          = 1'b1;
            cmd_out_d.tag            = alloc_tag8;
            cmd_out_d.tag_parity     = tag_par;
            cmd_out_d.command        = command_in.command;
            cmd_out_d.command_parity = cmd_par;
            cmd_out_d.address        = command_in.address;
            cmd_out_d.address_parity = addr_par;
            cmd_out_d.abt            = ABT_STRICT;
            cmd_out_d.context_handle = DEDICATED_CONTEXT;
            cmd_out_d.size           = command_in.size;
        end

        rsp_line_d = '0;
        if (response_valid && enabled && rsp_in_range) rsp_line_d = tag_table_q[rsp_idx];
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            free_q       <= '1;
            credits_q    <= '0;
            credit_max_q <= '0;
            enabled_q    <= 1'b0;
            cmd_out_q    <= '0;
            rsp_line_q   <= '0;
        end else begin
            free_q       <= free_d;
            credits_q    <= credits_d;
            credit_max_q <= credit_max_d;
            enabled_q    <= enabled;
            cmd_out_q    <= cmd_out_d;
            rsp_line_q   <= rsp_line_d;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(TAG_COUNT); i++) tag_table_q[i] <= '0;
        end else if (accept) begin
            tag_table_q[alloc_tag] <= command_in.cmd;
        end
    end

    assign command_out         = cmd_out_q;
    assign response_tag_id_out = rsp_line_q;

endmodule
